// File: rtl/axis_pixel_packer_pkg.sv
// Shared constants and helpers for the AXI-Stream pixel packer.
//   PIX_W        - width of one pixel (one byte lane)
//   PIX_PER_WORD - pixels carried by one output word
//   WORD_W       - output word width
//   KEEP_W       - byte-keep mask width
//   IDX_W        - width of the byte index inside a word
package axis_pixel_packer_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 4;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;
  localparam int KEEP_W       = PIX_PER_WORD;
  localparam int IDX_W        = 2;

  // Keep mask for a word whose final pixel lands in byte lane idx:
  // lanes 0..idx are valid, the rest are padding.
  function automatic logic [KEEP_W-1:0] keep_mask(input logic [IDX_W-1:0] idx);
    logic [KEEP_W-1:0] m;
    case (idx)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/axis_pixel_packer.sv
// axis_pixel_packer
// Packs a stream of 8-bit pixels into 32-bit AXI-Stream words for a DMA
// S2MM channel. The first pixel of a word sits in [7:0]. The word carrying
// the final pixel of a frame is flagged with o_data_last, and a short final
// word is padded with zero bytes and marked by o_data_keep. A word never
// straddles two frames.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_pixel_data        input pixel
//   i_pixel_data_valid  input valid
//   o_pixel_data_ready  input ready (combinational: output slot free or draining)
//   o_data              packed word
//   o_data_keep         byte-valid mask
//   o_data_last         last word of frame
//   o_data_valid        output valid
//   i_data_ready        downstream ready
//   o_frame_done        one-cycle pulse when a last word is accepted
//   o_frame_count       completed frames, wraps modulo 2^FCNT_W
module axis_pixel_packer
  import axis_pixel_packer_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int FCNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [PIX_W-1:0]  i_pixel_data,
  input  logic              i_pixel_data_valid,
  output logic              o_pixel_data_ready,
  output logic [WORD_W-1:0] o_data,
  output logic [KEEP_W-1:0] o_data_keep,
  output logic              o_data_last,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic              o_frame_done,
  output logic [FCNT_W-1:0] o_frame_count
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

  logic [WORD_W-PIX_W-1:0] acc_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [COL_W-1:0]        col_p0;
  logic [ROW_W-1:0]        row_p0;

  logic                    xfer;
  logic                    eof;
  logic                    word_done;
  logic                    accept;
  logic [WORD_W-1:0]       word_p0;
  logic [WORD_W-1:0]       acc_ext;

  // Ready depends only on the output register, so a word that completes
  // in this cycle always has a free slot to load into.
  assign o_pixel_data_ready = !o_data_valid || i_data_ready;
  assign xfer      = i_pixel_data_valid && o_pixel_data_ready;
  assign eof       = xfer && (col_p0 == COL_MAX) && (row_p0 == ROW_MAX);
  assign word_done = xfer && ((idx_p0 == 2'd3) || eof);
  assign accept    = o_data_valid && i_data_ready;
  assign acc_ext   = {{PIX_W{1'b0}}, acc_p0};

  // Assemble the outgoing word: bytes below idx come from the accumulator,
  // the current pixel goes to lane idx, and lanes above idx are zero so
  // stale bytes from the previous word never leak into a short word.
  always_comb begin
    word_p0 = '0;
    for (int b = 0; b < PIX_PER_WORD; b++) begin
      if (b < int'(idx_p0)) begin
        word_p0[b*PIX_W +: PIX_W] = acc_ext[b*PIX_W +: PIX_W];
      end else if (b == int'(idx_p0)) begin
        word_p0[b*PIX_W +: PIX_W] = i_pixel_data;
      end
    end
  end

  // ---- stage p0: accumulator and frame position ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_p0 <= '0;
      idx_p0 <= '0;
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (xfer) begin
      if (word_done) begin
        idx_p0 <= '0;
      end else begin
        case (idx_p0)
          2'd0:    acc_p0[7:0]   <= i_pixel_data;
          2'd1:    acc_p0[15:8]  <= i_pixel_data;
          default: acc_p0[23:16] <= i_pixel_data;
        endcase
        idx_p0 <= idx_p0 + 2'd1;
      end

      if (col_p0 == COL_MAX) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == ROW_MAX) ? '0 : row_p0 + ROW_W'(1);
      end else begin
        col_p0 <= col_p0 + COL_W'(1);
      end
    end
  end

  // ---- stage p1: output word register and frame bookkeeping ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data        <= '0;
      o_data_keep   <= '0;
      o_data_last   <= 1'b0;
      o_data_valid  <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_count <= '0;
    end else begin
      o_frame_done <= accept && o_data_last;
      if (accept && o_data_last) begin
        o_frame_count <= o_frame_count + FCNT_W'(1);
      end

      if (word_done) begin
        o_data       <= word_p0;
        o_data_keep  <= keep_mask(idx_p0);
        o_data_last  <= eof;
        o_data_valid <= 1'b1;
      end else if (accept) begin
        o_data_valid <= 1'b0;
      end
    end
  end

endmodule
